fifo_rr_arb: RTL and testbench

- Round-robin arbiter and packet scheduler sharing one fifo_1depth write port among NREQ producers.
- Each producer offers words tagged with a last flag. A multi-word packet holds the grant until its last word, so packets are never interleaved.
- The block drives fifo_we/fifo_dati and consumes the FIFO's full flag. The source id is appended to each word so the consumer can demultiplex.
- A length watchdog force-releases a runaway owner.

---
 rtl/fifo_rr_arb_if.sv | 28 ++
 rtl/fifo_rr_arb.sv | 116 +++++++++++
 tb/tb_fifo_rr_arb.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rr_arb_if.sv
// rtl/fifo_rr_arb_if.sv - requester, FIFO write-port and status bundle for fifo_rr_arb
// The master modport is the arbiter side; slave is the producer/FIFO side.
interface fifo_rr_arb_if #(
   parameter int NREQ = 4,
   parameter int IW   = 2,
   parameter int DW   = 8
);
   logic [NREQ-1:0]    req;
   logic [NREQ-1:0]    req_last;
   logic [NREQ*DW-1:0] req_dat;
   logic [NREQ-1:0]    ack;
   logic               fifo_we;
   logic [IW+DW-1:0]   fifo_dati;
   logic               fifo_full;
   logic               busy;
   logic [IW-1:0]      owner;
   logic               err;

   modport master (
      input  req, req_last, req_dat, fifo_full,
      output ack, fifo_we, fifo_dati, busy, owner, err
   );

   modport slave (
      output req, req_last, req_dat, fifo_full,
      input  ack, fifo_we, fifo_dati, busy, owner, err
   );
endinterface

// File: rtl/fifo_rr_arb.sv
// rtl/fifo_rr_arb.sv - round-robin packet scheduler onto a single FIFO write port
// Packets hold the grant until their last word; a length watchdog force-releases runaway owners.
module fifo_rr_arb #(
   parameter int NREQ   = 4,
   parameter int IW     = 2,
   parameter int DW     = 8,
   parameter int MAXLEN = 16
) (
   input  logic           clk,
   input  logic           clr_n,
   fifo_rr_arb_if.master  bus
);
   localparam int             LW       = $clog2(MAXLEN + 1);
   localparam logic [LW-1:0]  LEN_LAST = LW'(MAXLEN - 1);

   typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} st_t;

   st_t             r_st, w_st_nxt;
   logic [IW-1:0]   r_rr_ptr, w_rr_nxt;
   logic [IW-1:0]   r_owner, w_owner_nxt;
   logic [LW-1:0]   r_len, w_len_nxt;
   logic            r_err, w_err_nxt;

   logic            w_scan_vld;
   logic [IW-1:0]   w_scan_id;
   logic [IW-1:0]   w_gid;
   logic            w_xfer;
   logic [NREQ-1:0] w_ack;

   // Wraps at NREQ rather than 2^IW so non-power-of-two counts never name a phantom id.
   function automatic logic [IW-1:0] f_next_id(input logic [IW-1:0] id);
      return (id == IW'(NREQ - 1)) ? '0 : id + 1'b1;
   endfunction

   // Scan downward so the candidate closest to the pointer is the last one written.
   function automatic logic [IW:0] f_scan(input logic [NREQ-1:0] rq, input logic [IW-1:0] ptr);
      logic [IW:0] res;
      int          idx;
      res = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (rq[idx]) res = {1'b1, IW'(idx)};
      end
      return res;
   endfunction

   always_comb begin
      {w_scan_vld, w_scan_id} = f_scan(bus.req, r_rr_ptr);
   end

   always_comb begin
      w_gid  = r_owner;
      w_xfer = 1'b0;
      if (clr_n && !bus.fifo_full) begin
         if (r_st == ST_IDLE) begin
            w_gid  = w_scan_id;
            w_xfer = w_scan_vld;
         end else begin
            w_xfer = bus.req[r_owner];
         end
      end
      w_ack = '0;
      if (w_xfer) w_ack[w_gid] = 1'b1;
   end

   always_comb begin
      w_st_nxt    = r_st;
      w_rr_nxt    = r_rr_ptr;
      w_owner_nxt = r_owner;
      w_len_nxt   = r_len;
      w_err_nxt   = 1'b0;
      if (w_xfer) begin
         if (r_st == ST_IDLE) begin
            w_owner_nxt = w_gid;
            if (bus.req_last[w_gid]) begin
               w_rr_nxt  = f_next_id(w_gid);
               w_len_nxt = '0;
            end else begin
               w_st_nxt  = ST_LOCKED;
               w_len_nxt = LW'(1);
            end
         end else if (bus.req_last[r_owner] || r_len == LEN_LAST) begin
            w_st_nxt  = ST_IDLE;
            w_rr_nxt  = f_next_id(r_owner);
            w_len_nxt = '0;
            w_err_nxt = !bus.req_last[r_owner];
         end else begin
            w_len_nxt = r_len + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_st     <= ST_IDLE;
         r_rr_ptr <= '0;
         r_owner  <= '0;
         r_len    <= '0;
         r_err    <= 1'b0;
      end else begin
         r_st     <= w_st_nxt;
         r_rr_ptr <= w_rr_nxt;
         r_owner  <= w_owner_nxt;
         r_len    <= w_len_nxt;
         r_err    <= w_err_nxt;
      end
   end

   assign bus.ack       = w_ack;
   assign bus.fifo_we   = w_xfer;
   assign bus.fifo_dati = {w_gid, bus.req_dat[int'(w_gid)*DW +: DW]};
   assign bus.busy      = (r_st == ST_LOCKED);
   assign bus.owner     = r_owner;
   assign bus.err       = r_err;
endmodule

// File: tb/tb_fifo_rr_arb.sv
// tb/tb_fifo_rr_arb.sv - bench for fifo_rr_arb at NREQ=4 and NREQ=3
// Directed vector table, hand sequences, and random traffic against a packet-level model.
module tb_fifo_rr_arb;
   localparam int MAXLEN = 16;

   logic clk = 1'b0;
   logic clr_n = 1'b0;
   always #5 clk = ~clk;

   fifo_rr_arb_if #(.NREQ(4), .IW(2), .DW(8)) ifa ();
   fifo_rr_arb_if #(.NREQ(3), .IW(2), .DW(8)) ifb ();

   fifo_rr_arb #(.NREQ(4), .IW(2), .DW(8), .MAXLEN(MAXLEN)) u_a (.clk(clk), .clr_n(clr_n), .bus(ifa.master));
   fifo_rr_arb #(.NREQ(3), .IW(2), .DW(8), .MAXLEN(MAXLEN)) u_b (.clk(clk), .clr_n(clr_n), .bus(ifb.master));

   int checks = 0;
   int errors = 0;

   logic [3:0] a_req, a_last;
   logic       a_full;
   logic [7:0] a_dat [4];
   logic [2:0] b_req, b_last;
   logic       b_full;
   logic [7:0] b_dat [3];

   int m_locked [2];
   int m_ptr    [2];
   int m_owner  [2];
   int m_len    [2];
   int m_err    [2];

   int         g_a, g_b;
   logic [3:0] o_ack_a;
   logic       o_busy_a, o_err_a;
   logic [2:0] o_ack_b;

   typedef struct {
      logic [3:0] req;
      logic [3:0] last;
      logic       full;
      logic [3:0] ack;
      logic       busy;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic mdl_reset();
      for (int u = 0; u < 2; u++) begin
         m_locked[u] = 0; m_ptr[u] = 0; m_owner[u] = 0; m_len[u] = 0; m_err[u] = 0;
      end
   endtask

   // One cycle of the packet-level rules: pick a winner, then advance the packet bookkeeping.
   task automatic mdl(input int u, input int n, input logic [7:0] rq, input logic [7:0] ls,
                      input logic full, output int g);
      g = -1;
      if (!full) begin
         if (m_locked[u] != 0) begin
            if (rq[m_owner[u]]) g = m_owner[u];
         end else begin
            for (int k = 0; k < n; k++) begin
               int j;
               j = (m_ptr[u] + k) % n;
               if (rq[j] && g < 0) g = j;
            end
         end
      end
      m_err[u] = 0;
      if (g >= 0) begin
         if (m_locked[u] == 0) begin
            m_owner[u] = g;
            if (ls[g]) begin
               m_ptr[u] = (g + 1) % n;
               m_len[u] = 0;
            end else begin
               m_locked[u] = 1;
               m_len[u]    = 1;
            end
         end else if (ls[g] || m_len[u] + 1 == MAXLEN) begin
            m_err[u]    = ls[g] ? 0 : 1;
            m_locked[u] = 0;
            m_ptr[u]    = (g + 1) % n;
            m_len[u]    = 0;
         end else begin
            m_len[u] = m_len[u] + 1;
         end
      end
   endtask

   task automatic step();
      logic [3:0] ea;
      logic [2:0] eb;
      ifa.req = a_req; ifa.req_last = a_last; ifa.fifo_full = a_full;
      ifa.req_dat = {a_dat[3], a_dat[2], a_dat[1], a_dat[0]};
      ifb.req = b_req; ifb.req_last = b_last; ifb.fifo_full = b_full;
      ifb.req_dat = {b_dat[2], b_dat[1], b_dat[0]};
      @(negedge clk);
      chk("a_busy", ifa.busy, m_locked[0]);
      chk("a_owner", ifa.owner, m_owner[0]);
      chk("a_err", ifa.err, m_err[0]);
      chk("b_busy", ifb.busy, m_locked[1]);
      chk("b_owner", ifb.owner, m_owner[1]);
      chk("b_err", ifb.err, m_err[1]);
      mdl(0, 4, {4'b0, a_req}, {4'b0, a_last}, a_full, g_a);
      mdl(1, 3, {5'b0, b_req}, {5'b0, b_last}, b_full, g_b);
      ea = (g_a >= 0) ? 4'(1 << g_a) : 4'b0;
      eb = (g_b >= 0) ? 3'(1 << g_b) : 3'b0;
      chk("a_ack", ifa.ack, ea);
      chk("a_we", ifa.fifo_we, g_a >= 0);
      if (g_a >= 0) chk("a_dati", ifa.fifo_dati, {g_a[1:0], a_dat[g_a]});
      chk("b_ack", ifb.ack, eb);
      chk("b_we", ifb.fifo_we, g_b >= 0);
      if (g_b >= 0) chk("b_dati", ifb.fifo_dati, {g_b[1:0], b_dat[g_b]});
      o_ack_a = ifa.ack; o_busy_a = ifa.busy; o_err_a = ifa.err; o_ack_b = ifb.ack;
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic [3:0] rq, input logic [3:0] ls, input logic fl,
                               input logic [3:0] ak, input logic by);
      vec_t v;
      v.req = rq; v.last = ls; v.full = fl; v.ack = ak; v.busy = by;
      return v;
   endfunction

   initial begin
      // round robin, all single-word
      for (int i = 0; i < 8; i++) tbl.push_back(mk(4'b1111, 4'b1111, 1'b0, 4'(1 << (i % 4)), 1'b0));
      // 3-word packet from req0 with req1 waiting
      tbl.push_back(mk(4'b0011, 4'b0010, 1'b0, 4'b0001, 1'b0));
      tbl.push_back(mk(4'b0011, 4'b0010, 1'b0, 4'b0001, 1'b1));
      tbl.push_back(mk(4'b0011, 4'b0011, 1'b0, 4'b0001, 1'b1));
      tbl.push_back(mk(4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b0));
      // owner 2 stalled by a full FIFO
      tbl.push_back(mk(4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b0));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(4'b0110, 4'b0010, 1'b1, 4'b0000, 1'b1));
      tbl.push_back(mk(4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1));
      tbl.push_back(mk(4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b1));

      mdl_reset();
      a_req = '0; a_last = '0; a_full = 1'b0; b_req = '0; b_last = '0; b_full = 1'b0;
      for (int i = 0; i < 4; i++) a_dat[i] = 8'(8'h10 * i + 3);
      for (int i = 0; i < 3; i++) b_dat[i] = 8'(8'h20 * i + 5);
      ifa.req = 4'b1111; ifa.req_last = 4'b1111; ifa.fifo_full = 1'b0; ifa.req_dat = '0;
      ifb.req = 3'b111; ifb.req_last = 3'b111; ifb.fifo_full = 1'b0; ifb.req_dat = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ack", ifa.ack, 4'b0);
      chk("rst_we", ifa.fifo_we, 1'b0);
      chk("rst_busy", ifa.busy, 1'b0);
      chk("rst_owner", ifa.owner, 2'd0);
      chk("rst_err", ifa.err, 1'b0);
      clr_n = 1'b1;

      foreach (tbl[i]) begin
         a_req = tbl[i].req; a_last = tbl[i].last; a_full = tbl[i].full;
         a_dat[i % 4] = 8'($urandom);
         step();
         chk("tbl_ack", o_ack_a, tbl[i].ack);
         chk("tbl_busy", o_busy_a, tbl[i].busy);
      end

      // watchdog: req3 never ends its packet, req0 waits with a single word
      a_req = 4'b1001; a_last = 4'b0001;
      for (int i = 0; i < MAXLEN; i++) begin
         step();
         chk("wd_ack", o_ack_a, 4'b1000);
      end
      step();
      chk("wd_err", o_err_a, 1'b1);
      chk("wd_busy", o_busy_a, 1'b0);
      chk("wd_next", o_ack_a, 4'b0001);
      a_req = 4'b0000;
      step();
      chk("wd_err_clr", o_err_a, 1'b0);

      // reset in the middle of a packet owned by req1
      a_req = 4'b0010; a_last = 4'b0000;
      repeat (5) step();
      clr_n = 1'b0;
      #1;
      chk("mid_rst_ack", ifa.ack, 4'b0);
      chk("mid_rst_we", ifa.fifo_we, 1'b0);
      chk("mid_rst_busy", ifa.busy, 1'b0);
      mdl_reset();
      @(posedge clk);
      #1;
      clr_n = 1'b1;
      a_req = 4'b1010; a_last = 4'b1010;
      step();
      chk("post_rst_grant", o_ack_a, 4'b0010);
      a_req = 4'b0000;
      step();

      // three requesters: id 3 must never appear
      b_req = 3'b101; b_last = 3'b111;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("n3_ack", o_ack_b, (i % 2 == 0) ? 3'b001 : 3'b100);
      end
      b_req = 3'b000;
      step();

      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < 4; i++) begin
            if (g_a == i || !a_req[i]) begin
               a_req[i]  = ($urandom_range(0, 2) != 0);
               a_last[i] = ($urandom_range(0, 5) == 0);
               a_dat[i]  = 8'($urandom);
            end
         end
         for (int i = 0; i < 3; i++) begin
            if (g_b == i || !b_req[i]) begin
               b_req[i]  = ($urandom_range(0, 2) != 0);
               b_last[i] = ($urandom_range(0, 3) == 0);
               b_dat[i]  = 8'($urandom);
            end
         end
         a_full = ($urandom_range(0, 3) == 0);
         b_full = ($urandom_range(0, 4) == 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
